// File: rtl/lut_cfg_loader.sv
// Serial truth-table loader for a bank of L_FRAG cells: deframes address/data/parity
// bit streams, commits good frames into per-LUT registers and offers registered readback.
module lut_cfg_loader #(
  parameter int          NUM_LUTS = 8,
  parameter int          ADDR_W   = 3,
  parameter logic [15:0] INIT_TT  = 16'h0000
) (
  input  logic                     QCK,
  input  logic                     QRT,
  input  logic                     cfg_data,
  input  logic                     cfg_valid,
  input  logic                     cfg_sof,
  output logic                     cfg_ready,
  input  logic                     err_clr,
  output logic [NUM_LUTS*16-1:0]   frag_bits,
  output logic                     load_done,
  output logic                     err_parity,
  output logic                     err_addr,
  output logic                     err_sync,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [15:0]              rd_data
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, PAR, COMMIT} state_t;

  localparam logic [4:0] ADDR_LAST = 5'(ADDR_W - 1);

  state_t            state, state_nxt;
  logic [4:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_sh, addr_nxt;
  logic [15:0]       data_sh, data_nxt;
  logic              par_acc, par_nxt;
  logic              accept, start;
  logic              set_sync, set_par, set_addr, commit_ok;
  logic              wr_en;
  logic [15:0]       rd_sel;
  logic [15:0]       entry [NUM_LUTS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NUM_LUTS);
  endfunction

  assign accept = cfg_valid && cfg_ready;
  assign wr_en  = (state == COMMIT) && load_done;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_sh;
    data_nxt  = data_sh;
    par_nxt   = par_acc;
    start     = 1'b0;
    set_sync  = 1'b0;
    set_par   = 1'b0;
    set_addr  = 1'b0;
    commit_ok = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cfg_sof) start = 1'b1;
          else         set_sync = 1'b1;
        end
      end
      ADDR, DATA, PAR: begin
        if (accept && cfg_sof) begin
          // A new start-of-frame mid-frame drops the partial frame and restarts on this bit.
          set_sync = 1'b1;
          start    = 1'b1;
        end else if (accept) begin
          par_nxt = par_acc ^ cfg_data;
          if (state == ADDR) begin
            addr_nxt = ADDR_W'({addr_sh, cfg_data});
            if (cnt == ADDR_LAST) begin
              state_nxt = DATA;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 5'd1;
            end
          end else if (state == DATA) begin
            data_nxt = {data_sh[14:0], cfg_data};
            if (cnt == 5'd15) begin
              state_nxt = PAR;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 5'd1;
            end
          end else begin
            set_par   = par_acc ^ cfg_data;
            set_addr  = !in_range(addr_sh);
            commit_ok = !(par_acc ^ cfg_data) && in_range(addr_sh);
            state_nxt = COMMIT;
          end
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      addr_nxt = ADDR_W'(cfg_data);
      data_nxt = '0;
      par_nxt  = cfg_data;
      if (ADDR_W == 1) begin
        state_nxt = DATA;
        cnt_nxt   = '0;
      end else begin
        state_nxt = ADDR;
        cnt_nxt   = 5'd1;
      end
    end
  end

  // Readback sees the committing value one cycle after COMMIT, same as frag_bits.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_LUTS; i++)
      if (rd_addr == ADDR_W'(i)) rd_sel = entry[i];
    if (wr_en && rd_addr == addr_sh) rd_sel = data_sh;
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_sh    <= '0;
      data_sh    <= '0;
      par_acc    <= 1'b0;
      cfg_ready  <= 1'b0;
      load_done  <= 1'b0;
      err_parity <= 1'b0;
      err_addr   <= 1'b0;
      err_sync   <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < NUM_LUTS; i++) entry[i] <= INIT_TT;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      addr_sh    <= addr_nxt;
      data_sh    <= data_nxt;
      par_acc    <= par_nxt;
      cfg_ready  <= (state_nxt != COMMIT);
      load_done  <= commit_ok;
      err_parity <= set_par  | (err_parity & ~err_clr);
      err_addr   <= set_addr | (err_addr   & ~err_clr);
      err_sync   <= set_sync | (err_sync   & ~err_clr);
      rd_data    <= rd_sel;
      for (int i = 0; i < NUM_LUTS; i++)
        if (wr_en && addr_sh == ADDR_W'(i)) entry[i] <= data_sh;
    end
  end

  for (genvar g = 0; g < NUM_LUTS; g++) begin : g_frag
    assign frag_bits[16*g +: 16] = entry[g];
  end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Bench for lut_cfg_loader: frame-level bit-queue model compared every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_lut_cfg_loader;
  localparam int N  = 6;
  localparam int AW = 3;
  localparam int F  = AW + 17;

  logic            QCK = 1'b0;
  logic            QRT = 1'b1;
  logic            cfg_data = 1'b0, cfg_valid = 1'b0, cfg_sof = 1'b0, err_clr = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic            cfg_ready, load_done, err_parity, err_addr, err_sync;
  logic [N*16-1:0] frag_bits;
  logic [15:0]     rd_data;

  lut_cfg_loader #(.NUM_LUTS(N), .ADDR_W(AW), .INIT_TT(16'h0000)) dut (
    .QCK(QCK), .QRT(QRT), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_sof(cfg_sof),
    .cfg_ready(cfg_ready), .err_clr(err_clr), .frag_bits(frag_bits), .load_done(load_done),
    .err_parity(err_parity), .err_addr(err_addr), .err_sync(err_sync),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 QCK = ~QCK;

  int checks = 0, errors = 0, ld_count = 0;
  bit cmp_en = 0, rand_bg = 0;

  // Model: the frame is simply the list of bits collected so far.
  bit          mq[$];
  logic [15:0] m_mem [N];
  bit          m_commit, m_good, m_ready, m_ld, m_ep, m_ea, m_es;
  int          m_addr;
  logic [15:0] m_data, m_rd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N; i++) m_mem[i] = 16'h0000;
    m_commit = 0; m_good = 0; m_ready = 0; m_ld = 0;
    m_ep = 0; m_ea = 0; m_es = 0; m_rd = 16'h0; m_addr = 0; m_data = 16'h0;
  endtask

  task automatic model_step();
    bit sp, sa, ss, nld, nrdy;
    int a, x;
    logic [15:0] d;
    sp = 0; sa = 0; ss = 0; nld = 0; nrdy = 1;
    if (m_commit) begin
      if (m_good) m_mem[m_addr] = m_data;
      m_commit = 0;
    end else if (cfg_valid && m_ready) begin
      if (cfg_sof) begin
        if (mq.size() != 0) ss = 1;
        mq.delete();
        mq.push_back(cfg_data);
      end else if (mq.size() == 0) begin
        ss = 1;
      end else begin
        mq.push_back(cfg_data);
      end
      if (mq.size() == F) begin
        a = 0; x = 0; d = 16'h0;
        for (int i = 0; i < AW; i++) a = a * 2 + int'(mq[i]);
        for (int i = 0; i < 16; i++) d = {d[14:0], mq[AW+i]};
        for (int i = 0; i < F; i++) x = x ^ int'(mq[i]);
        m_addr = a; m_data = d;
        m_good = (x == 0) && (a < N);
        sp = (x != 0); sa = (a >= N);
        nld = m_good; nrdy = 0; m_commit = 1;
        mq.delete();
      end
    end
    m_ld = nld; m_ready = nrdy;
    m_ep = sp | (m_ep & !err_clr);
    m_ea = sa | (m_ea & !err_clr);
    m_es = ss | (m_es & !err_clr);
    m_rd = (int'(rd_addr) < N) ? m_mem[rd_addr] : 16'h0;
  endtask

  function automatic logic [N*16-1:0] exp_frag();
    logic [N*16-1:0] v;
    for (int i = 0; i < N; i++) v[16*i +: 16] = m_mem[i];
    return v;
  endfunction

  initial forever begin
    @(posedge QCK or posedge QRT);
    if (QRT) model_reset();
    else     model_step();
  end

  initial forever begin
    @(negedge QCK);
    if (cmp_en) begin
      chk("frag_bits",  128'(frag_bits),  128'(exp_frag()));
      chk("cfg_ready",  128'(cfg_ready),  128'(m_ready));
      chk("load_done",  128'(load_done),  128'(m_ld));
      chk("err_parity", 128'(err_parity), 128'(m_ep));
      chk("err_addr",   128'(err_addr),   128'(m_ea));
      chk("err_sync",   128'(err_sync),   128'(m_es));
      chk("rd_data",    128'(rd_data),    128'(m_rd));
    end
    if (load_done === 1'b1) ld_count++;
  end

  initial forever begin
    @(negedge QCK);
    if (rand_bg) begin
      rd_addr = AW'($urandom_range(0, 7));
      err_clr = ($urandom_range(0, 15) == 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge QCK);
      cfg_valid = 0; cfg_sof = 0;
    end
  endtask

  task automatic drive_bit(input logic d, input logic s, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) begin
      @(negedge QCK);
      cfg_valid = 0; cfg_data = 1'($urandom); cfg_sof = 1'($urandom);
    end
    @(negedge QCK);
    guard = 0;
    while (cfg_ready !== 1'b1 && guard < 50) begin
      cfg_valid = 0;
      @(negedge QCK);
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout: cfg_ready stuck at %b, required 1", cfg_ready);
    end
    cfg_valid = 1; cfg_data = d; cfg_sof = s;
  endtask

  task automatic send_frame(input logic [2:0] a, input logic [15:0] d, input logic p,
                            input int maxgap, input int nbits);
    logic [19:0] fr;
    fr = {a, d, p};
    for (int i = 0; i < nbits; i++)
      drive_bit(fr[19-i], i == 0, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic pulse_clr();
    @(negedge QCK); err_clr = 1;
    @(negedge QCK); err_clr = 0;
  endtask

  int ld0;

  initial begin
    repeat (3) @(negedge QCK);
    cmp_en = 1;
    chk("rst_ready", 128'(cfg_ready), 128'(1'b0));
    chk("rst_frag",  128'(frag_bits), 128'(0));
    chk("rst_rd",    128'(rd_data),   128'(0));
    chk("rst_flags", 128'({err_parity, err_addr, err_sync, load_done}), 128'(4'b0000));
    QRT = 0;
    #1 chk("ready_first_cycle", 128'(cfg_ready), 128'(1'b0));
    @(negedge QCK);
    chk("ready_after", 128'(cfg_ready), 128'(1'b1));

    ld0 = ld_count;
    send_frame(3'd5, 16'hA5C3, 1'b0, 0, F);
    idle(4);
    chk("basic_ld_pulses", 128'(ld_count - ld0), 128'(1));
    chk("basic_frag", 128'(frag_bits), 128'({16'hA5C3, 80'h0}));
    chk("basic_flags", 128'({err_parity, err_addr, err_sync}), 128'(3'b000));

    ld0 = ld_count;
    send_frame(3'd5, 16'hA5C3, 1'b1, 0, F);
    idle(4);
    chk("par_flag", 128'(err_parity), 128'(1'b1));
    chk("par_ld_pulses", 128'(ld_count - ld0), 128'(0));
    chk("par_frag", 128'(frag_bits), 128'({16'hA5C3, 80'h0}));

    @(negedge QCK); err_clr = 1;
    @(negedge QCK); err_clr = 0;
    chk("clr_parity", 128'(err_parity), 128'(1'b0));

    send_frame(3'd7, 16'h00FF, 1'b1, 0, F);
    idle(3);
    rd_addr = 3'd7;
    idle(2);
    chk("addr_flag", 128'(err_addr), 128'(1'b1));
    chk("addr_par_ok", 128'(err_parity), 128'(1'b0));
    chk("addr_rd7", 128'(rd_data), 128'(16'h0000));
    chk("addr_frag", 128'(frag_bits), 128'({16'hA5C3, 80'h0}));
    pulse_clr();

    send_frame(3'd3, 16'($urandom), 1'b0, 0, 9);
    send_frame(3'd2, 16'h8001, 1'b1, 0, F);
    idle(4);
    chk("resync_flag", 128'(err_sync), 128'(1'b1));
    chk("resync_frag", 128'(frag_bits),
        128'({16'hA5C3, 16'h0, 16'h0, 16'h8001, 16'h0, 16'h0}));
    chk("resync_other_flags", 128'({err_parity, err_addr}), 128'(2'b00));

    rd_addr = 3'd0;
    send_frame(3'd0, 16'hFFFE, 1'b1, 3, F);
    @(negedge QCK);
    chk("stall_ready_commit", 128'(cfg_ready), 128'(1'b0));
    chk("stall_ld", 128'(load_done), 128'(1'b1));
    chk("stall_rd_old", 128'(rd_data), 128'(16'h0000));
    cfg_valid = 0;
    @(negedge QCK);
    chk("stall_ready_back", 128'(cfg_ready), 128'(1'b1));
    chk("stall_rd_new", 128'(rd_data), 128'(16'hFFFE));
    chk("stall_frag0", 128'(frag_bits[15:0]), 128'(16'hFFFE));

    send_frame(3'd4, 16'h1234, 1'b0, 0, 12);
    @(negedge QCK);
    cfg_valid = 0;
    #2 QRT = 1;
    #1;
    chk("mid_rst_frag",  128'(frag_bits), 128'(0));
    chk("mid_rst_ready", 128'(cfg_ready), 128'(1'b0));
    chk("mid_rst_rd",    128'(rd_data),   128'(0));
    chk("mid_rst_flags", 128'({err_parity, err_addr, err_sync, load_done}), 128'(4'b0000));
    @(negedge QCK);
    QRT = 0;
    #1 chk("mid_rel_ready0", 128'(cfg_ready), 128'(1'b0));
    @(negedge QCK);
    chk("mid_rel_ready1", 128'(cfg_ready), 128'(1'b1));
    send_frame(3'd4, 16'h1234, ^{3'd4, 16'h1234}, 0, F);
    idle(4);
    chk("fresh_frag", 128'(frag_bits), 128'({16'h0, 16'h1234, 64'h0}));

    rand_bg = 1;
    for (int it = 0; it < 40; it++) begin
      int          kind;
      logic [2:0]  a;
      logic [15:0] d;
      logic        p;
      kind = int'($urandom_range(0, 5));
      a = 3'($urandom_range(0, 7));
      d = 16'($urandom);
      p = ^{a, d};
      if ($urandom_range(0, 3) == 0) p = ~p;
      if (kind == 0)      drive_bit(1'($urandom), 1'b0, 0);
      else if (kind == 1) send_frame(a, d, p, 2, int'($urandom_range(1, F - 1)));
      else                send_frame(a, d, p, 2, F);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    rand_bg = 0;
    idle(2);
    err_clr = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lut_cfg_loader.md
Name: lut_cfg_loader

Overview:
- Serial configuration writer for a bank of L_FRAG logic cells.
- Receives framed serial truth-table data over a valid/ready bit stream, checks parity and address, and commits 16-bit truth tables into per-LUT registers.
- The registers drive the fragBitInfo inputs of the bank.
- Provides registered readback of any stored truth table, plus sticky error flags for the host.

Parameters:
- NUM_LUTS, 8, number of 16-bit truth-table registers (2..2**ADDR_W).
- ADDR_W, 3, frame address field width in bits.
- INIT_TT, 16'h0000, reset value of every truth-table register.

Ports:
- QCK  input  1  clock, rising edge.
- QRT  input  1  asynchronous active-high reset.
- cfg_data  input  1  serial configuration bit.
- cfg_valid  input  1  cfg_data is valid this cycle.
- cfg_sof  input  1  start-of-frame marker; qualifies the accepted bit as the first bit of a frame.
- cfg_ready  output  1  loader accepts a bit this cycle.
- err_clr  input  1  clears the sticky error flags.
- frag_bits  output  NUM_LUTS*16  truth tables; slice [16*i+15:16*i] feeds LUT i.
- load_done  output  1  one-cycle pulse when a frame commits.
- err_parity  output  1  sticky parity failure.
- err_addr  output  1  sticky address out of range (addr >= NUM_LUTS).
- err_sync  output  1  sticky framing error.
- rd_addr  input  ADDR_W  readback address.
- rd_data  output  16  registered readback data.

Behaviour:
- Bit acceptance: a bit is accepted on a rising QCK edge when cfg_valid && cfg_ready.
- Frame format, F = ADDR_W+17 bits (20 at defaults):
  - ADDR_W address bits, MSB first;
  - 16 truth-table bits, bit 15 first;
  - 1 parity bit.
  - Parity is even: the XOR of all F bits must be 0.
- FSM states: IDLE, ADDR, DATA, PAR, COMMIT.
  - IDLE: an accepted bit with cfg_sof=1 loads address bit and goes to ADDR (or to DATA if ADDR_W==1). An accepted bit with cfg_sof=0 is discarded, sets err_sync, and the FSM stays in IDLE.
  - ADDR: shifts address bits; after ADDR_W bits -> DATA.
  - DATA: shifts 16 bits; bit counter 0..15; after 16 bits -> PAR.
  - PAR: accepts the parity bit -> COMMIT.
  - COMMIT: lasts exactly one cycle with cfg_ready=0, then -> IDLE.
    - If parity is good and addr < NUM_LUTS: write the shift register into entry addr; pulse load_done in the same cycle; the new value appears on frag_bits the next cycle.
    - Parity bad: no write; set err_parity.
    - Addr out of range: no write; set err_addr.
    - Both failures set both flags.
- Resync: an accepted bit with cfg_sof=1 while in ADDR, DATA or PAR does the following:
  - sets err_sync;
  - discards the partial frame;
  - treats that bit as the first address bit of a new frame.
  - The FSM goes to ADDR (or to DATA if ADDR_W==1), bit counter restarts at 1.
- cfg_valid=0 stalls the FSM indefinitely. No timeout.
- cfg_ready is registered:
  - 0 during reset and for the first cycle after QRT deasserts;
  - 0 in COMMIT;
  - 1 otherwise.
- Maximum throughput is one frame per F+1 cycles.
- err_clr=1 clears all three flags on the next edge.
  - If a set condition occurs in the same cycle, set wins.
  - Flags never clear otherwise.
- Readback: rd_data <= entry[rd_addr] every cycle (1-cycle latency).
  - If rd_addr >= NUM_LUTS, rd_data = 16'h0000.
  - Readback of the address being committed returns the old value in the COMMIT cycle and the new value one cycle later.
- Reset (asynchronous, QRT=1):
  - state=IDLE; all shift registers and counters 0;
  - all entries = INIT_TT;
  - rd_data=0, load_done=0, all error flags 0, cfg_ready=0.
- A reset asserted mid-frame aborts the frame; no partial write ever reaches frag_bits.
- frag_bits changes only on a committed write or on reset. Glitch-free: driven directly from registers.

Test Plan:
- Basic commit: after reset, send frame addr=5, data=16'hA5C3, parity=0 (20 bits, cfg_valid held high, sof on the first bit) -> load_done pulses once; frag_bits[95:80]=16'hA5C3; all other slices 0; no error flags set.
- Parity error: same frame with parity=1 -> err_parity=1; no load_done; frag_bits unchanged.
- Clear: pulse err_clr -> err_parity=0 on the next cycle.
- Address range: bench with NUM_LUTS=6, frame addr=7, data=16'h00FF, parity=1 -> err_addr=1; no write; rd_addr=7 gives rd_data=0.
- Resync: start a frame, then assert cfg_sof on the 10th bit followed by a full valid frame addr=2, data=16'h8001 (parity 1) -> err_sync=1; entry 2 = 16'h8001; no other entry written.
- Stalls and readback: random cfg_valid gaps inside a frame for addr=0, data=16'hFFFE (parity 1) -> same result as the gapless frame.
  - cfg_ready=0 exactly one cycle after the parity bit.
  - rd_addr=0 gives rd_data=16'hFFFE one cycle after commit.
- Reset mid-frame: assert QRT after 12 bits -> all outputs at reset values immediately (asynchronous).
  - After release, cfg_ready=0 for one cycle, then 1.
  - A fresh frame loads correctly.
